// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and constants for the 2:1 round-robin mux arbiter
package mux_arb_pkg;

   // Output stage occupancy: EMPTY means Y holds no word, FULL means Y_valid is high
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } arb_state_e;

   // Grant encoding doubles as the mux select value driven on S
   localparam logic GNT_A = 1'b0;
   localparam logic GNT_B = 1'b1;

   localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/rr_grant2.sv
// rtl/rr_grant2.sv - combinational two-way round-robin grant
module rr_grant2
   import mux_arb_pkg::*;
(
   input  logic A_valid,
   input  logic B_valid,
   input  logic last_grant,
   output logic gnt,
   output logic any
);

   // Contention goes to the side that did not win last; a lone requester always wins
   always_comb begin
      any = A_valid | B_valid;
      gnt = GNT_A;
      if (A_valid && B_valid) begin
         gnt = ~last_grant;
      end else if (B_valid) begin
         gnt = GNT_B;
      end
   end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// rtl/mux2_rr_arbiter.sv - round-robin 2:1 mux with one-entry registered output stage (optional MUX_ARB_STATS_EN grant counters)
module mux2_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
`ifdef MUX_ARB_STATS_EN
   ,
   parameter int CNT_W = 16
`endif
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              A_valid,
   input  logic [DATA_W-1:0] A,
   output logic              A_ready,
   input  logic              B_valid,
   input  logic [DATA_W-1:0] B,
   output logic              B_ready,
   output logic              S,
   output logic              Y_valid,
   output logic [DATA_W-1:0] Y,
   input  logic              Y_ready
`ifdef MUX_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0]  cnt_A,
   output logic [CNT_W-1:0]  cnt_B
`endif
);

   arb_state_e state;
   arb_state_e state_next;
   logic       last_grant;
   logic       gnt;
   logic       any;
   logic       can_load;
   logic       load;

   rr_grant2 u_grant (
      .A_valid    (A_valid),
      .B_valid    (B_valid),
      .last_grant (last_grant),
      .gnt        (gnt),
      .any        (any)
   );

   // The stage can take a word when empty or when its current word leaves this cycle;
   // reset suppresses accepts so no handshake is reported while state is being cleared
   assign can_load = (state == ST_EMPTY) || Y_ready;
   assign load     = !rst && can_load && any;
   assign A_ready  = load && (gnt == GNT_A);
   assign B_ready  = load && (gnt == GNT_B);
   assign Y_valid  = (state == ST_FULL);

   // Occupancy state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // Next occupancy: a load always leaves the stage full; a drain without load empties it
   always_comb begin
      state_next = state;
      case (state)
         ST_EMPTY: begin
            if (load) begin
               state_next = ST_FULL;
            end
         end
         ST_FULL: begin
            if (load) begin
               state_next = ST_FULL;
            end else if (Y_ready) begin
               state_next = ST_EMPTY;
            end
         end
         default: state_next = ST_EMPTY;
      endcase
   end

   // Capture the granted word and its select; last_grant starts at B so A wins first contention
   always_ff @(posedge clk) begin
      if (rst) begin
         Y          <= '0;
         S          <= GNT_A;
         last_grant <= GNT_B;
      end else if (load) begin
         Y          <= (gnt == GNT_B) ? B : A;
         S          <= gnt;
         last_grant <= gnt;
      end
   end

`ifdef MUX_ARB_STATS_EN
   // Per-port accept counters, saturating at all-ones
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_A <= '0;
         cnt_B <= '0;
      end else begin
         if (A_ready && (cnt_A != '1)) begin
            cnt_A <= cnt_A + CNT_W'(1);
         end
         if (B_ready && (cnt_B != '1)) begin
            cnt_B <= cnt_B + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Sequencing controller for the team's 2:1 mux datapath.
- Two requesters (A, B) each present a valid/data pair. The block arbitrates round-robin, drives the mux select S, and captures the selected word into a one-entry registered output stage with a valid/ready handshake.
- Sits between two producer channels and a single shared downstream consumer.

Parameters:
DATA_W, 8, width of each requester's data word and of Y.
CNT_W, 16, width of the grant counters (used only with MUX_ARB_STATS_EN).

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
A_valid  input  1  requester A has a word
A  input  DATA_W  requester A data
A_ready  output  1  A word accepted this cycle (combinational)
B_valid  input  1  requester B has a word
B  input  DATA_W  requester B data
B_ready  output  1  B word accepted this cycle (combinational)
S  output  1  registered select of the word held in Y (0=A, 1=B)
Y_valid  output  1  output stage holds a word
Y  output  DATA_W  registered mux output
Y_ready  input  1  consumer accepts Y this cycle

Behaviour:
- Reset (rst=1 at clock edge, overrides everything):
  - Y_valid=0, Y=0, S=0.
  - last_grant=1, so A wins the first contention.
  - Counters cleared.
  - Reset mid-transfer drops the held word; no accept is reported during the reset cycle.
- State machine, two states:
  - EMPTY (Y_valid=0): go to FULL on load.
  - FULL (Y_valid=1):
    - Y_ready=1 with a load → stay FULL (back-to-back transfer).
    - Y_ready=1 without a load → EMPTY.
    - Y_ready=0 → hold; Y and S stay stable.
- can_load = (state==EMPTY) || Y_ready.
- Grant, combinational:
  - Only A_valid → gnt=0.
  - Only B_valid → gnt=1.
  - Both valid → gnt = ~last_grant.
  - Neither valid → no grant.
- load = can_load && (A_valid || B_valid).
- A_ready = load && gnt==0; B_ready = load && gnt==1. Never both high.
- On load, at the clock edge: Y ← selected data, S ← gnt, last_grant ← gnt, Y_valid ← 1.
- Latency: one cycle from accept to Y_valid. Throughput: one word per cycle when Y_ready is held high.
- Fairness: under continuous contention, grants alternate A, B, A, B… A single requester gets every slot.
- Boundaries:
  - Requesters may change data only after their ready pulse.
  - A_valid/B_valid dropping while not granted is legal; nothing is lost.
  - Y_ready while EMPTY is ignored.
- No arithmetic in the datapath; Y is a pure registered copy of the selected word.

Optional Feature:
- Macro MUX_ARB_STATS_EN.
- Defined:
  - Adds outputs cnt_A and cnt_B (CNT_W each). Each counts accepts on its port.
  - Counters saturate at all-ones (no wrap) and clear on rst.
- Undefined:
  - Ports and counter logic absent.
  - All other behaviour identical.

Decomposition:
- Shared package mux_arb_pkg holds:
  - state enum (ST_EMPTY, ST_FULL)
  - GNT_A=0 / GNT_B=1 constants
  - default DATA_W
- Natural sub-module: rr_grant2, the combinational two-way round-robin grant taking (A_valid, B_valid, last_grant) and returning (gnt, any).
- Output register and FSM stay in the top module.

Test Plan:
- Reset: hold rst=1 for 2 cycles with A_valid=B_valid=1 → Y_valid=0, Y=0, S=0, A_ready=B_ready=0.
- Single requester: A_valid=1, A=8'h3C, Y_ready=1 → A_ready=1 in cycle 0; cycle 1 Y=8'h3C, S=0, Y_valid=1. B_ready stays 0.
- Contention: A=8'h11, B=8'h22, both valid for 4 cycles, Y_ready=1 → grants A,B,A,B; Y sequence 11,22,11,22; S sequence 0,1,0,1.
- Backpressure: FULL with Y=8'h11; Y_ready=0 for 3 cycles while B_valid=1 → Y and S stable, B_ready=0. When Y_ready=1 → B_ready=1, Y=8'h22 on the next cycle.
- Reset mid-operation: FULL with Y=8'h22, assert rst for one cycle → next cycle Y_valid=0, Y=0. Then with both valid, first grant goes to A.
- MUX_ARB_STATS_EN: 5 A accepts, 3 B accepts → cnt_A=5, cnt_B=3. With CNT_W=2 and 5 A accepts → cnt_A saturates at 3.
